// File: rtl/div_result_cache.sv
// ---------------------------------------------------------------------------
// div_result_cache
//
// Single-entry result cache in front of the integer divider. It remembers the
// quotient, remainder and operand key of the last division the divider
// completed. A later div/rem with the same operands, signedness and width is
// then served in one cycle (E->M) without starting the divider. The common
// case is the fused DIV-then-REM idiom.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   StallM              M-stage stall (E->M register holds)
//   FlushE, FlushM      flush of the E / M stage instruction
//   IntDivE             div/rem instruction of any type in E
//   DivSignedE, W64E    signed op / W-type op (tie W64E to 0 for XLEN=32)
//   ForwardedSrcAE/BE   dividend / divisor (forwarded)
//   DivBusyE            divider busy
//   QuotM, RemM         divider results in M
//   DivReqE             divider request (IntDivE & ~HitE)
//   HitE, HitM          op served from the cache, in E / in M
//   QuotOutM, RemOutM   cached results on a hit, divider results otherwise
// ---------------------------------------------------------------------------
module div_result_cache #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallM,
    input  logic            FlushE,
    input  logic            FlushM,
    input  logic            IntDivE,
    input  logic            DivSignedE,
    input  logic            W64E,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    input  logic            DivBusyE,
    input  logic [XLEN-1:0] QuotM,
    input  logic [XLEN-1:0] RemM,
    output logic            DivReqE,
    output logic            HitE,
    output logic            HitM,
    output logic [XLEN-1:0] QuotOutM,
    output logic [XLEN-1:0] RemOutM
);

    localparam int KW = 2 * XLEN + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_valid;
    logic [KW-1:0]   r_cached_key;
    logic [KW-1:0]   r_pend_key;
    logic [XLEN-1:0] r_cached_q;
    logic [XLEN-1:0] r_cached_r;
    logic            r_hit_m;

    logic [KW-1:0]   w_key;
    logic            w_hit_cached;
    logic            w_hit_pend;
    logic            w_hit;
    logic            w_start;
    logic            w_latch_pend;
    logic            w_capture;

    // Upper operand bits of W ops are part of the key on purpose: no masking.
    assign w_key = {ForwardedSrcAE, ForwardedSrcBE, DivSignedE, W64E};

    always_comb begin
        w_hit_cached = r_valid && (w_key == r_cached_key);
        // The op in M is being captured at this very edge; forward its key.
        w_hit_pend   = (r_state == CAPT) && (w_key == r_pend_key);
        // The op the divider is working on must never be served from the cache.
        w_hit        = IntDivE && (r_state != WAIT) && (w_hit_cached || w_hit_pend);
        w_start      = IntDivE && !w_hit && !StallM && !FlushE;
        w_latch_pend = (r_state != WAIT) && w_start;
        w_capture    = (r_state == CAPT);

        w_next = r_state;
        case (r_state)
            IDLE, CAPT: w_next = w_start ? WAIT : IDLE;
            WAIT: begin
                if (FlushE)
                    w_next = IDLE;
                else if (!DivBusyE && !StallM)
                    w_next = CAPT;
                else
                    w_next = WAIT;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_cached_key <= '0;
            r_pend_key   <= '0;
            r_cached_q   <= '0;
            r_cached_r   <= '0;
            r_hit_m      <= 1'b0;
        end else begin
            if (w_latch_pend)
                r_pend_key <= w_key;
            // Captured even when M is stalled or flushed: results depend only
            // on the operands, so a flushed op still yields a valid entry.
            if (w_capture) begin
                r_cached_q   <= QuotM;
                r_cached_r   <= RemM;
                r_cached_key <= r_pend_key;
                r_valid      <= 1'b1;
            end
            if (FlushM)
                r_hit_m <= 1'b0;
            else if (!StallM)
                r_hit_m <= w_hit;
        end
    end

    assign HitE     = w_hit;
    assign DivReqE  = IntDivE && !w_hit;
    assign HitM     = r_hit_m;
    assign QuotOutM = r_hit_m ? r_cached_q : QuotM;
    assign RemOutM  = r_hit_m ? r_cached_r : RemM;

endmodule

// File: tb/tb_div_result_cache.sv
// ---------------------------------------------------------------------------
// tb_div_result_cache
//
// Drives div/rem ops through an emulated E/M pipeline and divider. A reference
// model tracks the most recently completed divider op (key) and computes
// RISC-V division results arithmetically; cache hits are predicted from it.
// ---------------------------------------------------------------------------
module tb_div_result_cache;

    localparam int XLEN = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             StallM = 1'b0;
    logic             FlushE = 1'b0;
    logic             FlushM = 1'b0;
    logic             IntDivE = 1'b0;
    logic             DivSignedE = 1'b0;
    logic             W64E = 1'b0;
    logic [XLEN-1:0]  ForwardedSrcAE = '0;
    logic [XLEN-1:0]  ForwardedSrcBE = '0;
    logic             DivBusyE = 1'b0;
    logic [XLEN-1:0]  QuotM = '0;
    logic [XLEN-1:0]  RemM = '0;
    logic             DivReqE;
    logic             HitE;
    logic             HitM;
    logic [XLEN-1:0]  QuotOutM;
    logic [XLEN-1:0]  RemOutM;

    always #5 clk = ~clk;

    div_result_cache #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .StallM         (StallM),
        .FlushE         (FlushE),
        .FlushM         (FlushM),
        .IntDivE        (IntDivE),
        .DivSignedE     (DivSignedE),
        .W64E           (W64E),
        .ForwardedSrcAE (ForwardedSrcAE),
        .ForwardedSrcBE (ForwardedSrcBE),
        .DivBusyE       (DivBusyE),
        .QuotM          (QuotM),
        .RemM           (RemM),
        .DivReqE        (DivReqE),
        .HitE           (HitE),
        .HitM           (HitM),
        .QuotOutM       (QuotOutM),
        .RemOutM        (RemOutM)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model of what sits in M this cycle.
    bit          m_has = 1'b0;
    bit          m_hit = 1'b0;
    logic [63:0] m_q = '0;
    logic [63:0] m_r = '0;

    // Model of the cache: key of the last op the divider completed.
    bit           ref_valid = 1'b0;
    logic [129:0] ref_key = '0;

    localparam logic [63:0] NEG7 = 64'hFFFF_FFFF_FFFF_FFF9;

    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                    input bit s, input bit w,
                                    output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == '1) begin
                q32 = a32; r32 = '0;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = '1; r = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = '0;
            end else if (s) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Divider outputs in M: real results for a divider-served op, noise otherwise
    // so that a missing cache mux would be visible.
    task automatic drive_m();
        if (m_has && !m_hit) begin
            QuotM = m_q;
            RemM  = m_r;
        end else begin
            QuotM = {$urandom, $urandom};
            RemM  = {$urandom, $urandom};
        end
    endtask

    task automatic check_m(input string tag);
        if (m_has) begin
            n_tests++;
            if (HitM !== m_hit) begin
                n_fail++;
                $display("FAIL %s HitM: got %b expected %b", tag, HitM, m_hit);
            end
            n_tests++;
            if (QuotOutM !== m_q || RemOutM !== m_r) begin
                n_fail++;
                $display("FAIL %s outM: got Q=%h R=%h expected Q=%h R=%h", tag, QuotOutM, RemOutM, m_q, m_r);
            end
        end else begin
            n_tests++;
            if (HitM !== 1'b0 || QuotOutM !== QuotM || RemOutM !== RemM) begin
                n_fail++;
                $display("FAIL %s bubbleM: got HitM=%b Q=%h R=%h expected HitM=0 Q=%h R=%h",
                         tag, HitM, QuotOutM, RemOutM, QuotM, RemM);
            end
        end
    endtask

    // Clock edge; update the M model from the controls held during the cycle.
    task automatic edge_adv(input bit adv, input bit hit, input logic [63:0] q, input logic [63:0] r);
        @(posedge clk);
        #1;
        if (reset || FlushM) begin
            m_has = 1'b0;
            m_hit = 1'b0;
        end else if (!StallM) begin
            m_has = adv;
            m_hit = hit;
            m_q   = q;
            m_r   = r;
        end
    endtask

    task automatic set_op(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w);
        IntDivE        = 1'b1;
        ForwardedSrcAE = a;
        ForwardedSrcBE = b;
        DivSignedE     = s;
        W64E           = w;
    endtask

    // One op through E: ns stall cycles first, then either a 1-cycle hit or
    // start + nb busy cycles + completion.
    task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w,
                            input int unsigned nb, input int unsigned ns, input string tag);
        logic [63:0]  q, r;
        logic [129:0] key;
        bit           exp_hit;
        ref_div(a, b, s, w, q, r);
        key     = {a, b, s, w};
        exp_hit = ref_valid && (key == ref_key);
        set_op(a, b, s, w);
        DivBusyE = 1'b0;
        FlushE   = 1'b0;
        for (int i = 0; i <= int'(ns); i++) begin
            StallM = (i < int'(ns));
            drive_m();
            #1;
            check_m(tag);
            n_tests++;
            if (HitE !== exp_hit || DivReqE !== !exp_hit) begin
                n_fail++;
                $display("FAIL %s issueE: got HitE=%b DivReqE=%b expected HitE=%b DivReqE=%b",
                         tag, HitE, DivReqE, exp_hit, !exp_hit);
            end
            edge_adv(exp_hit && i == int'(ns), 1'b1, q, r);
        end
        StallM = 1'b0;
        if (!exp_hit) begin
            for (int i = 0; i <= int'(nb); i++) begin
                DivBusyE = (i < int'(nb));
                drive_m();
                #1;
                check_m(tag);
                n_tests++;
                if (HitE !== 1'b0 || DivReqE !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s waitE: got HitE=%b DivReqE=%b expected HitE=0 DivReqE=1",
                             tag, HitE, DivReqE);
                end
                edge_adv(i == int'(nb), 1'b0, q, r);
            end
            DivBusyE  = 1'b0;
            ref_valid = 1'b1;
            ref_key   = key;
        end
        IntDivE = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            IntDivE        = 1'b0;
            ForwardedSrcAE = {$urandom, $urandom};
            ForwardedSrcBE = {$urandom, $urandom};
            StallM         = 1'b0;
            DivBusyE       = 1'b0;
            drive_m();
            #1;
            check_m("idle");
            n_tests++;
            if (HitE !== 1'b0 || DivReqE !== 1'b0) begin
                n_fail++;
                $display("FAIL idle E: got HitE=%b DivReqE=%b expected 0 0", HitE, DivReqE);
            end
            edge_adv(1'b0, 1'b0, 64'd0, 64'd0);
        end
    endtask

    // A cycle with no E op in which the M outputs are compared to fixed values.
    task automatic look_m(input string tag, input logic [63:0] eq, input logic [63:0] er);
        IntDivE = 1'b0;
        drive_m();
        #1;
        check_m(tag);
        n_tests++;
        if (HitM !== 1'b1 || QuotOutM !== eq || RemOutM !== er) begin
            n_fail++;
            $display("FAIL %s fixed: got HitM=%b Q=%h R=%h expected HitM=1 Q=%h R=%h",
                     tag, HitM, QuotOutM, RemOutM, eq, er);
        end
        edge_adv(1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m_has = 1'b0;
        repeat (2) begin
            drive_m();
            edge_adv(1'b0, 1'b0, 64'd0, 64'd0);
        end
        drive_m();
        #1;
        check_m("reset_held");
        reset  = 1'b0;
        ref_valid = 1'b0;
        // All-zero key equals the cleared CachedKey; Valid=0 must block a hit.
        set_op(64'd0, 64'd0, 1'b0, 1'b0);
        StallM = 1'b1;
        drive_m();
        #1;
        check_m("reset");
        n_tests++;
        if (HitE !== 1'b0 || DivReqE !== 1'b1) begin
            n_fail++;
            $display("FAIL reset E: got HitE=%b DivReqE=%b expected HitE=0 DivReqE=1", HitE, DivReqE);
        end
        edge_adv(1'b0, 1'b0, 64'd0, 64'd0);
        StallM  = 1'b0;
        IntDivE = 1'b0;
        idle(1);
    endtask

    task automatic test_basic_hit();
        drive_op(64'd100, 64'd7, 1'b0, 1'b0, 3, 0, "divu_100_7");
        drive_op(64'd100, 64'd7, 1'b0, 1'b0, 3, 0, "remu_100_7");
        look_m("remu_hit", 64'd14, 64'd2);
        idle(1);
    endtask

    task automatic test_signedness();
        drive_op(NEG7, 64'd2, 1'b1, 1'b0, 3, 0, "div_m7_2");
        drive_op(NEG7, 64'd2, 1'b1, 1'b0, 3, 0, "rem_m7_2");
        look_m("rem_m7_2_hit", 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        drive_op(NEG7, 64'd2, 1'b0, 1'b0, 3, 0, "divu_m7_2");
        idle(1);
    endtask

    task automatic test_div_zero();
        drive_op(64'd5, 64'd0, 1'b1, 1'b0, 0, 0, "div_5_0");
        idle(1);
        drive_op(64'd5, 64'd0, 1'b1, 1'b0, 0, 0, "div_5_0_again");
        look_m("div0_hit", '1, 64'd5);
    endtask

    task automatic test_flush_wait();
        set_op(64'd1234, 64'd10, 1'b0, 1'b0);
        DivBusyE = 1'b0;
        drive_m();
        #1;
        check_m("flush_start");
        n_tests++;
        if (HitE !== 1'b0 || DivReqE !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_start E: got HitE=%b DivReqE=%b expected 0 1", HitE, DivReqE);
        end
        edge_adv(1'b0, 1'b0, 64'd0, 64'd0);
        DivBusyE = 1'b1;
        FlushE   = 1'b1;
        drive_m();
        #1;
        check_m("flush_wait");
        edge_adv(1'b0, 1'b0, 64'd0, 64'd0);
        FlushE   = 1'b0;
        DivBusyE = 1'b0;
        idle(2);
        // Entry from before the flush must still be there; the flushed op must not.
        drive_op(64'd5, 64'd0, 1'b1, 1'b0, 0, 0, "after_flush_old");
        drive_op(64'd1234, 64'd10, 1'b0, 1'b0, 2, 0, "after_flush_reissue");
        idle(1);
    endtask

    task automatic test_capt_forward();
        drive_op(64'd77, 64'd3, 1'b1, 1'b0, 2, 0, "fwd_div");
        drive_op(64'd77, 64'd3, 1'b1, 1'b0, 0, 0, "fwd_rem");
        look_m("fwd_rem_hit", 64'd25, 64'd2);
        drive_op(64'd88, 64'd5, 1'b0, 1'b0, 2, 0, "fwd_div_stall");
        drive_op(64'd88, 64'd5, 1'b0, 1'b0, 0, 2, "fwd_rem_stall");
        look_m("fwd_stall_hit", 64'd17, 64'd3);
        idle(1);
    endtask

    task automatic test_flush_m();
        set_op(64'd88, 64'd5, 1'b0, 1'b0);
        FlushM = 1'b1;
        drive_m();
        #1;
        check_m("flushm");
        n_tests++;
        if (HitE !== 1'b1) begin
            n_fail++;
            $display("FAIL flushm E: got HitE=%b expected 1", HitE);
        end
        edge_adv(1'b0, 1'b0, 64'd0, 64'd0);
        FlushM  = 1'b0;
        IntDivE = 1'b0;
        idle(1);
    endtask

    task automatic test_reset_mid_wait();
        set_op(64'd999, 64'd4, 1'b0, 1'b0);
        drive_m();
        #1;
        edge_adv(1'b0, 1'b0, 64'd0, 64'd0);
        DivBusyE = 1'b1;
        drive_m();
        #1;
        check_m("rst_wait");
        reset    = 1'b1;
        IntDivE  = 1'b0;
        edge_adv(1'b0, 1'b0, 64'd0, 64'd0);
        reset     = 1'b0;
        DivBusyE  = 1'b0;
        ref_valid = 1'b0;
        drive_op(64'd88, 64'd5, 1'b0, 1'b0, 2, 0, "rst_old_key");
        idle(1);
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        bit          s, w;
        int unsigned nb, ns;
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0: a = 64'd100;
                1: a = NEG7;
                2: a = 64'd5;
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 3))
                0: b = 64'd7;
                1: b = 64'd2;
                2: b = 64'd0;
                default: b = {$urandom, $urandom};
            endcase
            s  = $urandom_range(0, 1) == 1;
            w  = $urandom_range(0, 1) == 1;
            nb = ((w && b[31:0] == 32'd0) || (!w && b == 64'd0)) ? 0 : $urandom_range(1, 4);
            ns = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            drive_op(a, b, s, w, nb, ns, "rand");
            if ($urandom_range(0, 3) == 0)
                idle(1);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_signedness();
        test_div_zero();
        test_flush_wait();
        test_capt_forward();
        test_flush_m();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule
